// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, transfer status codes and
// frame layout helpers used by both the transmit and receive paths.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_SEND,
        ST_ACK,
        ST_WAIT_IDLE
    } ps2_tx_state_e;

    localparam logic [1:0] PS2_ACK_OK  = 2'b00;
    localparam logic [1:0] PS2_NACK    = 2'b01;
    localparam logic [1:0] PS2_TIMEOUT = 2'b10;

    // start + 8 data + parity + stop
    localparam int PS2_FRAME_BITS = 11;
    localparam int PS2_DATA_BITS  = 8;

    function automatic logic ps2_parity(input logic [PS2_DATA_BITS-1:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the raw PS/2 clock and data pins, with falling-edge
// strobes. Flops reset to 1 because both open-collector lines idle high.
module ps2_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic clk_in,
    input  logic data_in,
    output logic clk_sync,
    output logic data_sync,
    output logic clk_fall,
    output logic data_fall
);

    // bit 0 = clock line, bit 1 = data line
    logic [1:0] meta_q, meta_d;
    logic [1:0] sync_q, sync_d;
    logic [1:0] prev_q, prev_d;

    always_comb begin
        meta_d = {data_in, clk_in};
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '1;
            sync_q <= '1;
            prev_q <= '1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign clk_sync  = sync_q[0];
    assign data_sync = sync_q[1];
    assign clk_fall  = prev_q[0] & ~sync_q[0];
    assign data_fall = prev_q[1] & ~sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter. Drives the shared open-collector
// lines only through registered pull-low enables; busy masks the receiver.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES   = 60,
    parameter int REQ_SETUP_CYCLES = 2,
    parameter int TIMEOUT_CYCLES   = 8000
) (
    input  logic       CLK_CPU,
    input  logic       resetn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic [1:0] tx_status,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PAY_W   = PS2_FRAME_BITS - 1;
    localparam logic [3:0] STOP_IDX = 4'(PAY_W - 1);

    logic clk_sync, data_sync, clk_fall, data_fall_unused;

    ps2_line_sync u_sync (
        .clk       (CLK_CPU),
        .rst_n     (resetn),
        .clk_in    (ps2_clk_in),
        .data_in   (ps2_data_in),
        .clk_sync  (clk_sync),
        .data_sync (data_sync),
        .clk_fall  (clk_fall),
        .data_fall (data_fall_unused)
    );

    ps2_tx_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic [PAY_W-1:0] frame_q, frame_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             tx_done_q, tx_done_d;
    logic [1:0]       status_q, status_d;
    logic             nack_q, nack_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        frame_d   = frame_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        tx_done_d = 1'b0;
        status_d  = status_q;
        nack_d    = nack_q;
        case (state_q)
            ST_IDLE: begin
                if (tx_valid) begin
                    // payload is shifted out after the start bit: data LSB first, parity, stop
                    frame_d   = {1'b1, ps2_parity(tx_data), tx_data};
                    bit_idx_d = '0;
                    cnt_d     = CNT_W'(INHIBIT_CYCLES - 1);
                    clk_oe_d  = 1'b1;
                    data_oe_d = 1'b0;
                    state_d   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (cnt_q == '0) begin
                    data_oe_d = 1'b1;
                    cnt_d     = CNT_W'(REQ_SETUP_CYCLES - 1);
                    state_d   = ST_REQ;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_REQ: begin
                if (cnt_q == '0) begin
                    clk_oe_d = 1'b0;
                    cnt_d    = CNT_W'(TIMEOUT_CYCLES - 1);
                    state_d  = ST_SEND;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_SEND, ST_ACK, ST_WAIT_IDLE: begin
                // watchdog expiry takes priority over any line event this cycle
                if (cnt_q == '0) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    status_d  = PS2_TIMEOUT;
                    tx_done_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (state_q == ST_SEND && clk_fall) begin
                        data_oe_d = ~frame_q[bit_idx_q];
                        bit_idx_d = bit_idx_q + 1'b1;
                        if (bit_idx_q == STOP_IDX)
                            state_d = ST_ACK;
                    end
                    if (state_q == ST_ACK && clk_fall) begin
                        nack_d  = data_sync;
                        state_d = ST_WAIT_IDLE;
                    end
                    if (state_q == ST_WAIT_IDLE && clk_sync && data_sync) begin
                        status_d  = nack_q ? PS2_NACK : PS2_ACK_OK;
                        tx_done_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_CPU or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            frame_q   <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            tx_done_q <= 1'b0;
            status_q  <= PS2_ACK_OK;
            nack_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            frame_q   <= frame_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            tx_done_q <= tx_done_d;
            status_q  <= status_d;
            nack_q    <= nack_d;
        end
    end

    assign tx_ready    = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign tx_done     = tx_done_q;
    assign tx_status   = status_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a keyboard model on wired-AND lines clocks
// frames at 40 CLK_CPU per bit and ACKs, NACKs or stays silent.
module tb_ps2_host_tx;

    logic       CLK_CPU = 1'b0;
    logic       resetn  = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, tx_done;
    logic [1:0] tx_status;
    logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;

    logic dev_clk_low   = 1'b0;
    logic dev_data_low  = 1'b0;
    logic clk_force     = 1'b0;
    logic clk_force_val = 1'b1;

    assign ps2_clk_in  = clk_force ? clk_force_val : ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    always #5 CLK_CPU = ~CLK_CPU;

    ps2_host_tx #(
        .INHIBIT_CYCLES   (60),
        .REQ_SETUP_CYCLES (2),
        .TIMEOUT_CYCLES   (8000)
    ) dut (
        .CLK_CPU     (CLK_CPU),
        .resetn      (resetn),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .tx_done     (tx_done),
        .tx_status   (tx_status),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    int checks   = 0;
    int failures = 0;

    // Transfer monitor, sampled on the falling edge
    int         done_cnt = 0;
    int         acc_cnt  = 0;
    int         viol_cnt = 0;
    logic       in_xfer  = 1'b0;
    logic [1:0] done_status = 2'b00;
    logic [1:0] done_oe     = 2'b00;
    logic [7:0] acc_log[$];

    always @(negedge CLK_CPU) begin
        if (!resetn) begin
            in_xfer = 1'b0;
        end else begin
            if (tx_done) begin
                done_cnt++;
                in_xfer     = 1'b0;
                done_status = tx_status;
                done_oe     = {ps2_clk_oe, ps2_data_oe};
            end else if (in_xfer && (!busy || tx_ready)) begin
                viol_cnt++;
            end
            if (tx_valid && tx_ready) begin
                acc_cnt++;
                acc_log.push_back(tx_data);
                in_xfer = 1'b1;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation still running at %0t, limit 5000000", $time);
        $fatal(1, "global timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK_CPU);
        #1;
    endtask

    // Keyboard side of one host transfer; nclk = device clocks (11 = full frame + ACK clock)
    task automatic dev_run(input int nclk, input bit nack, output logic [10:0] bits,
                           output int inh, output int req, output bit ok);
        int n;
        ok = 1'b1; bits = '0; inh = 0; req = 0; n = 0;
        while (!ps2_clk_oe && n < 200) begin step(); n++; end
        if (!ps2_clk_oe) begin ok = 1'b0; return; end
        while (!ps2_data_oe && inh < 200) begin step(); inh++; end
        while (ps2_clk_oe && req < 200) begin step(); req++; end
        if (ps2_clk_oe) begin ok = 1'b0; return; end
        if (nclk == 0) return;
        repeat (20) step();
        bits[0] = ps2_data_in;
        for (int i = 1; i <= 10 && i <= nclk; i++) begin
            dev_clk_low = 1'b1;
            repeat (20) step();
            dev_clk_low = 1'b0;
            bits[i] = ps2_data_in;
            repeat (20) step();
        end
        if (nclk >= 11) begin
            dev_data_low = !nack;
            repeat (5) step();
            dev_clk_low = 1'b1;
            repeat (20) step();
            dev_clk_low = 1'b0;
            repeat (5) step();
            dev_data_low = 1'b0;
        end
    endtask

    task automatic wait_done(input int base, output bit ok);
        int n;
        n = 0;
        while (done_cnt <= base && n < 20000) begin step(); n++; end
        ok = (done_cnt > base);
    endtask

    task automatic send(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
    endtask

    initial begin
        logic [10:0] bits;
        int inh, req, base, n, acc0, viol0, idx0;
        bit ok;

        repeat (3) step();
        chk("rst_ready",  32'(tx_ready), 32'd1);
        chk("rst_busy",   32'(busy), 32'd0);
        chk("rst_done",   32'(tx_done), 32'd0);
        chk("rst_status", 32'(tx_status), 32'd0);
        chk("rst_oe",     32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        resetn = 1'b1;
        step();

        // 0xED, ACK
        base = done_cnt;
        send(8'hED);
        dev_run(11, 1'b0, bits, inh, req, ok);
        chk("ed_req_seen", 32'(ok), 32'd1);
        chk("ed_inhibit_cycles", 32'(inh), 32'd60);
        chk("ed_req_cycles", 32'(req), 32'd2);
        chk("ed_frame", 32'(bits), 32'({1'b1, 1'b1, 8'hED, 1'b0}));
        wait_done(base, ok);
        chk("ed_done_seen", 32'(ok), 32'd1);
        chk("ed_status", 32'(done_status), 32'd0);
        chk("ed_ready_after", 32'(tx_ready), 32'd1);

        // 0xF4, NACK
        base = done_cnt;
        send(8'hF4);
        dev_run(11, 1'b1, bits, inh, req, ok);
        chk("f4_req_seen", 32'(ok), 32'd1);
        chk("f4_frame", 32'(bits), 32'({1'b1, 1'b0, 8'hF4, 1'b0}));
        wait_done(base, ok);
        chk("f4_done_seen", 32'(ok), 32'd1);
        chk("f4_status", 32'(done_status), 32'd1);
        chk("f4_oe_at_done", 32'(done_oe), 32'd0);
        chk("f4_ready_after", 32'(tx_ready), 32'd1);
        chk("f4_status_held", 32'(tx_status), 32'd1);

        // 0x00, device silent: watchdog
        base = done_cnt;
        send(8'h00);
        dev_run(0, 1'b0, bits, inh, req, ok);
        chk("to_req_seen", 32'(ok), 32'd1);
        chk("to_start_held", 32'(ps2_data_oe), 32'd1);
        n = 0;
        while (!tx_done && n < 9000) begin step(); n++; end
        chk("to_cycles", 32'(n), 32'd8000);
        chk("to_status", 32'(tx_status), 32'd2);
        chk("to_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);

        // 0xFF, reset during bit 4
        step();
        base = done_cnt;
        send(8'hFF);
        dev_run(5, 1'b0, bits, inh, req, ok);
        chk("rstmid_partial", 32'(bits[5:0]), 32'({5'b11111, 1'b0}));
        resetn = 1'b0;
        #1;
        chk("rstmid_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        chk("rstmid_ready", 32'(tx_ready), 32'd1);
        chk("rstmid_busy", 32'(busy), 32'd0);
        repeat (3) step();
        resetn = 1'b1;
        repeat (30) step();
        chk("rstmid_no_done", 32'(done_cnt), 32'(base));
        send(8'hFF);
        dev_run(11, 1'b0, bits, inh, req, ok);
        chk("ff_frame", 32'(bits), 32'({1'b1, 1'b1, 8'hFF, 1'b0}));
        wait_done(base, ok);
        chk("ff_done_seen", 32'(ok), 32'd1);
        chk("ff_status", 32'(done_status), 32'd0);

        // tx_valid held high: 0xED then 0xAA
        base  = done_cnt;
        acc0  = acc_cnt;
        viol0 = viol_cnt;
        idx0  = acc_log.size();
        tx_data  = 8'hED;
        tx_valid = 1'b1;
        step();
        tx_data = 8'hAA;
        dev_run(11, 1'b0, bits, inh, req, ok);
        chk("hold1_frame", 32'(bits), 32'({1'b1, 1'b1, 8'hED, 1'b0}));
        wait_done(base, ok);
        chk("hold1_done_seen", 32'(ok), 32'd1);
        tx_valid = 1'b0;
        chk("hold2_accepted", 32'(busy), 32'd1);
        dev_run(11, 1'b0, bits, inh, req, ok);
        chk("hold2_frame", 32'(bits), 32'({1'b1, 1'b1, 8'hAA, 1'b0}));
        wait_done(base + 1, ok);
        chk("hold2_done_seen", 32'(ok), 32'd1);
        repeat (50) step();
        chk("hold_accepts", 32'(acc_cnt - acc0), 32'd2);
        chk("hold_dones", 32'(done_cnt - base), 32'd2);
        chk("hold_byte0", 32'(acc_log[idx0]), 32'h0ED);
        chk("hold_byte1", 32'(acc_log[idx0 + 1]), 32'h0AA);
        chk("hold_ready_busy", 32'(viol_cnt - viol0), 32'd0);

        // 0x55 with a clock glitch while the host inhibits
        base = done_cnt;
        send(8'h55);
        repeat (5) step();
        clk_force     = 1'b1;
        clk_force_val = 1'b1;
        repeat (4) step();
        clk_force_val = 1'b0;
        step();
        clk_force_val = 1'b1;
        repeat (4) step();
        clk_force = 1'b0;
        step();
        chk("glitch_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'({1'b1, 1'b0}));
        dev_run(11, 1'b0, bits, inh, req, ok);
        chk("glitch_frame", 32'(bits), 32'({1'b1, 1'b1, 8'h55, 1'b0}));
        wait_done(base, ok);
        chk("glitch_done_seen", 32'(ok), 32'd1);
        chk("glitch_status", 32'(done_status), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
